if_id_reg: RTL and testbench

- Pipeline register between the fetch stage (PC + instruction memory) and the decode stage of the 5-stage MIPS core with CP0 exception support.
- Captures the fetched PC and instruction, detects fetch-address exceptions (AdEL), and carries the branch-delay-slot flag.
- Supports stall (hold) and flush (exception entry / eret), and presents a valid bit so decode and CP0 can tell real instructions from bubbles.

---
 rtl/if_id_reg.sv | 98 +++++++++
 tb/tb_if_id_reg.sv | 134 +++++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch PC/instruction, flags AdEL, supports stall and flush.
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_TOP  = 32'h0000_6FFF,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        bd_d,
  output logic        valid_d,
  output logic        exc_valid_d,
  output logic [4:0]  exc_code_d
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  logic             fetch_err;
  logic [XLEN-1:0]  pc_n;
  logic [XLEN-1:0]  instr_n;
  logic             bd_n;
  logic             valid_n;
  logic             exc_valid_n;
  logic [EXC_W-1:0] exc_code_n;

  // Next-slot selection: flush beats stall beats load; default is hold.
  always_comb begin
    fetch_err   = (pc_f[1:0] != 2'b00) | (pc_f < IMEM_BASE) | (pc_f > IMEM_TOP);
    pc_n        = pc_d;
    instr_n     = instr_d;
    bd_n        = bd_d;
    valid_n     = valid_d;
    exc_valid_n = exc_valid_d;
    exc_code_n  = exc_code_d;
    if (flush) begin
      pc_n        = flush_pc;
      instr_n     = '0;
      bd_n        = 1'b0;
      valid_n     = 1'b0;
      exc_valid_n = 1'b0;
      exc_code_n  = '0;
    end else if (en) begin
      pc_n        = pc_f;
      instr_n     = fetch_err ? '0 : instr_f;
      bd_n        = bd_f;
      valid_n     = 1'b1;
      exc_valid_n = fetch_err;
      exc_code_n  = fetch_err ? EXC_ADEL : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d        <= RESET_PC;
      instr_d     <= '0;
      bd_d        <= 1'b0;
      valid_d     <= 1'b0;
      exc_valid_d <= 1'b0;
      exc_code_d  <= '0;
    end else begin
      pc_d        <= pc_n;
      instr_d     <= instr_n;
      bd_d        <= bd_n;
      valid_d     <= valid_n;
      exc_valid_d <= exc_valid_n;
      exc_code_d  <= exc_code_n;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en && !flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + XLEN'(1);
      if (flush && (flush_cnt != '1))         flush_cnt <= flush_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed plan steps plus randomized traffic vs. a reference model.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, en, flush, bd_f;
  logic [31:0] flush_pc, pc_f, instr_f;
  logic [31:0] pc_d, instr_d;
  logic        bd_d, valid_d, exc_valid_d;
  logic [4:0]  exc_code_d;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc, m_instr;
  logic        m_bd, m_valid, m_exc;
  logic [4:0]  m_code;

  if_id_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .flush_pc(flush_pc),
    .pc_f(pc_f), .instr_f(instr_f), .bd_f(bd_f),
    .pc_d(pc_d), .instr_d(instr_d), .bd_d(bd_d), .valid_d(valid_d),
    .exc_valid_d(exc_valid_d), .exc_code_d(exc_code_d)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legal fetch: word aligned and within the instruction memory window [0x3000, 0x6FFF].
  function automatic bit bad_fetch(input logic [31:0] pc);
    longint unsigned a = longint'(pc);
    return (a % 4 != 0) || (a < 64'h3000) || (a > 64'h6FFF);
  endfunction

  task automatic step(input logic r, input logic e, input logic f, input logic [31:0] fpc,
                      input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    reset = r; en = e; flush = f; flush_pc = fpc; pc_f = pc; instr_f = ins; bd_f = bd;
    if (r) begin
      m_pc = 32'h3000; m_instr = 0; m_bd = 0; m_valid = 0; m_exc = 0; m_code = 0;
`ifdef IF_ID_PERF_CNT_EN
      m_stall = 0; m_flush = 0;
`endif
    end else begin
`ifdef IF_ID_PERF_CNT_EN
      if (f && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (!e && !f && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
      if (f) begin
        m_pc = fpc; m_instr = 0; m_bd = 0; m_valid = 0; m_exc = 0; m_code = 0;
      end else if (e) begin
        m_pc = pc; m_bd = bd; m_valid = 1;
        m_exc = bad_fetch(pc);
        m_instr = m_exc ? 32'h0 : ins;
        m_code = m_exc ? 5'd4 : 5'd0;
      end
    end
    @(posedge clk);
    #1;
    chk("pc_d", pc_d, m_pc);
    chk("instr_d", instr_d, m_instr);
    chk("bd_d", {31'b0, bd_d}, {31'b0, m_bd});
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    chk("exc_valid_d", {31'b0, exc_valid_d}, {31'b0, m_exc});
    chk("exc_code_d", {27'b0, exc_code_d}, {27'b0, m_code});
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] picks [8];
    picks[0] = 32'h3000; picks[1] = 32'h6FFC; picks[2] = 32'h7000; picks[3] = 32'h2FFC;
    picks[4] = 32'hFFFF_FFFC; picks[5] = 32'h3002; picks[6] = 32'h4001; picks[7] = 32'h5A5C;
    reset = 1; en = 0; flush = 0; flush_pc = 0; pc_f = 0; instr_f = 0; bd_f = 0;
    #2;
    // Reset for two cycles, then first load.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h1234, 32'h3010, 32'hDEAD_BEEF, 1);
    step(0, 1, 0, 0, 32'h3000, 32'h3C01_1234, 0);
    // Stall holds for three cycles, then the pending fetch loads.
    step(0, 1, 0, 0, 32'h3004, 32'h0000_0021, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h3008, 32'hFFFF_0000 + i, 1);
    step(0, 1, 0, 0, 32'h3008, 32'h1111_2222, 0);
    // Address errors and boundaries.
    step(0, 1, 0, 0, 32'h3002, 32'hAAAA_AAAA, 0);
    step(0, 1, 0, 0, 32'h7000, 32'hBBBB_BBBB, 1);
    step(0, 1, 0, 0, 32'h6FFC, 32'hCCCC_CCCC, 0);
    step(0, 1, 0, 0, 32'hFFFF_FFFC, 32'hDDDD_DDDD, 0);
    step(0, 1, 0, 0, 32'h2FFC, 32'hEEEE_EEEE, 0);
    // Flush over stall, delay slot, then flush clears bd.
    step(0, 0, 1, 32'h4180, 32'h3020, 32'h1, 1);
    step(0, 1, 0, 0, 32'h3010, 32'h0800_0C00, 1);
    step(0, 1, 1, 32'h4180, 32'h3014, 32'h2, 1);
    // Reset mid-stall.
    step(0, 1, 0, 0, 32'h3018, 32'h3, 0);
    step(0, 0, 0, 0, 32'h301C, 32'h4, 0);
    step(1, 0, 0, 0, 32'h301C, 32'h4, 0);
`ifdef IF_ID_PERF_CNT_EN
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h3000, 32'h5, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 1, 32'h4180, 32'h3000, 32'h6, 0);
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    m_stall = 32'hFFFF_FFFF;
    step(0, 0, 0, 0, 32'h3000, 32'h7, 0);
    step(0, 0, 0, 0, 32'h3000, 32'h7, 0);
`endif
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? $urandom : picks[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) rpc = 32'h3000 + ($urandom_range(0, 16'h0FFF) << 2);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom, rpc, $urandom, 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
